key_counter_display: RTL
========================

Name: key_counter_display

Overview:
- Downstream consumer of the single-cycle debounced key pulses.
- Keeps a 4-digit BCD counter driven by inc/dec/clr pulses.
- Drives a time-multiplexed 4-digit seven-segment display with that counter.
- Sits between the debounce stages and the board's LED/7-seg pins in the led_display_ctrl design.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays enabled. Legal range 2..2^24-1; 1 ms at 100 MHz.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- inc_pulse  input  1  one-cycle pulse; increment counter
- dec_pulse  input  1  one-cycle pulse; decrement counter
- clr_pulse  input  1  one-cycle pulse; clear counter to 0000
- bcd  output  16  current count, 4 BCD nibbles, [15:12] = thousands
- an  output  4  one-hot digit enable, active-high; an[0] = ones digit
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high; dp always 0

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. While rst_n = 0:
  - bcd = 16'h0000, an = 4'b0000, seg = 8'h00
  - scan counter = 0, digit index = 0
- Counter update:
  - Registered; bcd reflects a pulse on the clock edge where the pulse is sampled high (1-cycle latency).
  - Priority: clr > (inc XOR dec).
  - inc and dec high in the same cycle (without clr): no change.
  - Pulses are level-sampled each cycle; a pulse held N cycles counts N times.
- BCD arithmetic:
  - Per-nibble carry/borrow chain; each nibble stays in 0..9.
  - Increment: a nibble at 9 becomes 0 and carries to the next digit.
  - Decrement: a nibble at 0 becomes 9 and borrows from the next digit.
  - Wrap: 9999 + inc -> 0000; 0000 + dec -> 9999.
- Scan timing:
  - Free-running scan counter counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0 -> 1 -> 2 -> 3 -> 0.
- Display outputs:
  - an and seg are registered from the current digit index and the current bcd, so they change on the same edge.
  - First edge after reset release: an = 4'b0001, seg = decode(bcd[3:0]).
  - A bcd change appears on the displayed digit one cycle after bcd updates.
- Segment decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values A-F cannot occur; decode them to 00.
- Reset asserted mid-scan or mid-update: all state returns to reset values immediately; no pending pulse is retained.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - While a digit is selected, seg = 8'h00 if that digit and every higher digit are 0.
  - The ones digit is never blanked, so 0000 shows "0" and 0042 shows "42".
  - an still cycles normally.
- Undefined: all four digits are always decoded, so leading zeros are shown.

Test Plan:
- Reset, SCAN_DIV=4: hold rst_n=0 for 3 cycles, then release.
  - During reset: bcd=0000, an=0000, seg=00.
  - First edge after release: an=0001, seg=3F.
  - Then an=0010 after 4 more cycles, 0100, 1000, back to 0001 (period 16 cycles).
- Increment carry: 10 single-cycle inc_pulse pulses from 0000 -> bcd=0010.
  - 1 further inc -> 0011.
  - Preload 0999 via dec from 1000, then inc -> 1000.
- Wrap: dec_pulse at 0000 -> 9999; inc_pulse at 9999 -> 0000; each exactly 1 cycle after the pulse.
- Simultaneous events:
  - inc+dec same cycle at 0005 -> stays 0005.
  - clr+inc same cycle at 0005 -> 0000.
  - clr+dec at 0000 -> 0000, no wrap.
- Display content, SCAN_DIV=4, count 0427, macro undefined: sampled per digit, seg = 7F? no — seg = 07 (an0), 5B (an1), 66 (an2), 3F (an3).
  - With LEADING_ZERO_BLANK_EN defined: an3 shows 00, the rest are unchanged.
  - Count 0000 with the macro: an0 = 3F, all others 00.
- Reset mid-operation: count 0123, assert rst_n low asynchronously between edges.
  - bcd, an and seg go to 0 without waiting for a clock edge.
  - After release, the count restarts from 0000.

Source files
------------

// File: rtl/key_counter_display.sv
// 4-digit BCD up/down/clear counter driven by debounced key pulses, with a
// time-multiplexed seven-segment scan. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module key_counter_display #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_pulse,
    input  logic        dec_pulse,
    input  logic        clr_pulse,
    output logic [15:0] bcd,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam logic [23:0] SCAN_LAST = 24'(SCAN_DIV - 1);

    logic [15:0] bcd_q, bcd_d, bcd_inc, bcd_dec;
    logic [23:0] scan_q, scan_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        cy, bw, blank;
    logic [3:0]  nib;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    // Ripple carry through the nibbles; a nibble that absorbs the carry stops the chain.
    always_comb begin
        bcd_inc = bcd_q;
        cy      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_dec = bcd_q;
        bw      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bw) begin
                if (bcd_q[i*4 +: 4] == 4'd0) begin
                    bcd_dec[i*4 +: 4] = 4'd9;
                end else begin
                    bcd_dec[i*4 +: 4] = bcd_q[i*4 +: 4] - 4'd1;
                    bw = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        if (clr_pulse)                   bcd_d = 16'h0000;
        else if (inc_pulse && !dec_pulse) bcd_d = bcd_inc;
        else if (dec_pulse && !inc_pulse) bcd_d = bcd_dec;
    end

    always_comb begin
        scan_d = scan_q + 24'd1;
        dig_d  = dig_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = 24'd0;
            dig_d  = dig_q + 2'd1;
        end
    end

    always_comb begin
        nib = bcd_q[dig_q*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Ones digit is never blanked so a zero count still shows "0".
        case (dig_q)
            2'd1:    blank = (bcd_q[15:4]  == 12'h000);
            2'd2:    blank = (bcd_q[15:8]  == 8'h00);
            2'd3:    blank = (bcd_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        an_d  = 4'b0001 << dig_q;
        seg_d = blank ? 8'h00 : {1'b0, dec7(nib)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            scan_q <= '0;
            dig_q  <= '0;
            an_q   <= '0;
            seg_q  <= '0;
        end else begin
            bcd_q  <= bcd_d;
            scan_q <= scan_d;
            dig_q  <= dig_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bcd = bcd_q;
    assign an  = an_q;
    assign seg = seg_q;
endmodule
